rk_video_gen: RTL and testbench



---
 rtl/rk_video_gen.sv | 212 +++++++++++++++++++++
 tb/tb_rk_video_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rk_video_gen.sv
// Character-raster video back end: programmable H/V sync timing, character
// clock strobe, registered font fetch address, per-cell attributes and palettes.
module rk_video_gen #(
  parameter int CLK_DIV      = 3,
  parameter int CHAR_W       = 6,
  parameter int H_TOTAL      = 533,
  parameter int H_SYNC_START = 478,
  parameter int H_SYNC_END   = 530,
  parameter int V_TOTAL      = 625,
  parameter int V_SYNC_START = 608,
  parameter int V_SYNC_END   = 614,
  parameter int COLOR_BITS   = 3,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                  clk50mhz,
  input  logic                  reset_n,
  input  logic [6:0]            ichar,
  input  logic [3:0]            line,
  input  logic                  vsp,
  input  logic                  lten,
  input  logic                  rvv,
  input  logic                  hglt,
  input  logic [1:0]            gpa,
  input  logic                  blink,
  input  logic [1:0]            mode,
  output logic [9:0]            font_addr,
  input  logic [7:0]            font_data,
  output logic                  cce,
  output logic                  hr,
  output logic                  vr,
  output logic                  frame_start,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_W  = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int V_W  = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int D_W  = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int B_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [H_W-1:0]  H_LAST  = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]  V_LAST  = V_W'(V_TOTAL - 1);
  localparam logic [D_W-1:0]  D_LAST  = D_W'(CHAR_W - 1);
  localparam logic [B_W-1:0]  B_LAST  = B_W'(BLINK_FRAMES - 1);

  localparam logic [H_W:0] HS_START = (H_W+1)'(H_SYNC_START);
  localparam logic [H_W:0] HS_END   = (H_W+1)'(H_SYNC_END);
  localparam logic [V_W:0] VS_START = (V_W+1)'(V_SYNC_START);
  localparam logic [V_W:0] VS_END   = (V_W+1)'(V_SYNC_END);

  localparam logic [COLOR_BITS-1:0] LVL_L   = {1'b1, {(COLOR_BITS-1){1'b0}}};
  localparam logic [COLOR_BITS-1:0] LVL_H   = '1;
  localparam logic [COLOR_BITS-1:0] LVL_LSB = {{(COLOR_BITS-1){1'b0}}, 1'b1};

  logic [PH_W-1:0]       phase_q, phase_d;
  logic [H_W-1:0]        h_cnt_q, h_cnt_d;
  logic [V_W-1:0]        v_cnt_q, v_cnt_d;
  logic [D_W-1:0]        d_cnt_q, d_cnt_d;
  logic [CHAR_W-1:0]     data_q, data_d;
  logic                  hglt_a_q, hglt_a_d;
  logic [1:0]            gpa_a_q, gpa_a_d;
  logic                  blink_a_q, blink_a_d;
  logic [B_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                  blink_ph_q, blink_ph_d;
  logic [9:0]            font_addr_q;
  logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic pe, h_wrap, v_wrap, d_last, frame_wrap, pix_on;
  logic [2:0] attr_c;
  logic unused_inputs;

  assign pe         = (phase_q == '0);
  assign h_wrap     = (h_cnt_q == H_LAST);
  assign v_wrap     = (v_cnt_q == V_LAST);
  assign d_last     = (d_cnt_q == D_LAST);
  assign frame_wrap = pe & h_wrap & v_wrap;
  assign attr_c     = {hglt_a_q, gpa_a_q};
  assign pix_on     = data_q[CHAR_W-1] & ~(blink_a_q & blink_ph_q);

  // Only the low glyph row bits and CHAR_W font bits take part in the raster.
  assign unused_inputs = ^{line[3], font_data};

  always_comb begin
    phase_d     = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    d_cnt_d     = d_cnt_q;
    data_d      = data_q;
    hglt_a_d    = hglt_a_q;
    gpa_a_d     = gpa_a_q;
    blink_a_d   = blink_a_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (pe) begin
      // Line wrap overrides the cell counter so a short final cell is dropped.
      if (h_wrap) begin
        h_cnt_d = '0;
        d_cnt_d = '0;
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
        d_cnt_d = d_last ? '0 : d_cnt_q + 1'b1;
      end
      if (d_last) begin
        if (lten) begin
          data_d = '1;
        end else if (vsp) begin
          data_d = '0;
        end else begin
          data_d = font_data[CHAR_W-1:0] ^ {CHAR_W{rvv}};
        end
        hglt_a_d  = hglt;
        gpa_a_d   = gpa;
        blink_a_d = blink;
      end else begin
        data_d = data_q << 1;
      end
      if (frame_wrap) begin
        if (blink_cnt_q == B_LAST) begin
          blink_cnt_d = '0;
          blink_ph_d  = ~blink_ph_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (pix_on) begin
      case (mode)
        2'd0: begin
          r_d = LVL_L;
          g_d = LVL_L;
          b_d = LVL_L;
        end
        2'd1: begin
          r_d = LVL_LSB;
          g_d = LVL_L;
          b_d = LVL_LSB;
        end
        2'd2: begin
          if (attr_c == 3'b000) begin
            r_d = LVL_L;
            g_d = LVL_L;
            b_d = LVL_L;
          end else begin
            r_d = attr_c[0] ? LVL_L : '0;
            g_d = attr_c[1] ? LVL_L : '0;
            b_d = attr_c[2] ? LVL_L : '0;
          end
        end
        default: begin
          r_d = hglt_a_q ? LVL_H : LVL_L;
          g_d = hglt_a_q ? LVL_H : LVL_L;
          b_d = hglt_a_q ? LVL_H : LVL_L;
        end
      endcase
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (!reset_n) begin
      phase_q     <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      d_cnt_q     <= '0;
      data_q      <= '0;
      hglt_a_q    <= 1'b0;
      gpa_a_q     <= '0;
      blink_a_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      font_addr_q <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      phase_q     <= phase_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      d_cnt_q     <= d_cnt_d;
      data_q      <= data_d;
      hglt_a_q    <= hglt_a_d;
      gpa_a_q     <= gpa_a_d;
      blink_a_q   <= blink_a_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      font_addr_q <= {ichar, line[2:0]};
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
    end
  end

  assign font_addr   = font_addr_q;
  assign cce         = (phase_q == PH_ONE) && (d_cnt_q == '0);
  assign hr          = ~(({1'b0, h_cnt_q} >= HS_START) && ({1'b0, h_cnt_q} < HS_END));
  assign vr          = ~(({1'b0, v_cnt_q} >= VS_START) && ({1'b0, v_cnt_q} < VS_END));
  assign frame_start = frame_wrap;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;

endmodule

// File: tb/tb_rk_video_gen.sv
// Bench for rk_video_gen with a reduced raster; pixel windows are checked
// against a scoreboard filled when each character/attribute setting is driven.
module tb_rk_video_gen;

  localparam int CLK_DIV    = 3;
  localparam int CHAR_W     = 6;
  localparam int H_TOTAL    = 40;
  localparam int HSS        = 26;
  localparam int HSE        = 32;
  localparam int V_TOTAL    = 10;
  localparam int VSS        = 6;
  localparam int VSE        = 8;
  localparam int CB         = 3;
  localparam int BF         = 2;
  localparam int LINE_CLKS  = H_TOTAL * CLK_DIV;
  localparam int FRAME_CLKS = LINE_CLKS * V_TOTAL;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [6:0]    ichar = '0;
  logic [3:0]    line = '0;
  logic          vsp = 1'b0, lten = 1'b0, rvv = 1'b0, hglt = 1'b0, blink = 1'b0;
  logic [1:0]    gpa = '0, mode = '0;
  logic [9:0]    font_addr;
  logic [7:0]    font_data = '0;
  logic          cce, hr, vr, frame_start;
  logic [CB-1:0] r, g, b;

  always #5 clk = ~clk;

  rk_video_gen #(
    .CLK_DIV(CLK_DIV), .CHAR_W(CHAR_W),
    .H_TOTAL(H_TOTAL), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .V_TOTAL(V_TOTAL), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
    .COLOR_BITS(CB), .BLINK_FRAMES(BF)
  ) dut (
    .clk50mhz(clk), .reset_n(reset_n), .ichar(ichar), .line(line),
    .vsp(vsp), .lten(lten), .rvv(rvv), .hglt(hglt), .gpa(gpa), .blink(blink),
    .mode(mode), .font_addr(font_addr), .font_data(font_data), .cce(cce),
    .hr(hr), .vr(vr), .frame_start(frame_start), .r(r), .g(g), .b(b)
  );

  function automatic logic [7:0] rom_f(input logic [9:0] a);
    case (a)
      10'h20A: return 8'h2A;
      10'h3FF: return 8'hFF;
      default: return a[7:0] ^ 8'h55;
    endcase
  endfunction

  always @(posedge clk) font_data <= rom_f(font_addr);

  function automatic logic [8:0] color_f(input logic on, input logic [1:0] md,
                                         input logic hg, input logic [1:0] gp);
    logic [2:0] c;
    c = {hg, gp};
    if (!on) return 9'b000_000_000;
    case (md)
      2'd0: return {3'b100, 3'b100, 3'b100};
      2'd1: return {3'b001, 3'b100, 3'b001};
      2'd2: begin
        if (c == 3'b000) return {3'b100, 3'b100, 3'b100};
        return {(c[0] ? 3'b100 : 3'b000), (c[1] ? 3'b100 : 3'b000), (c[2] ? 3'b100 : 3'b000)};
      end
      default: return hg ? 9'h1FF : {3'b100, 3'b100, 3'b100};
    endcase
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Frame count since reset and line-wrap cell marker (the cell right after
  // the short final cell carries no fresh glyph).
  int   fcount = 0;
  int   cce_since_rise = 100;
  logic hr_prev = 1'b1;
  logic wrap_win = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      fcount = 0;
      cce_since_rise = 100;
      wrap_win = 1'b0;
      hr_prev = 1'b1;
    end else begin
      if (frame_start) fcount++;
      if (hr && !hr_prev) cce_since_rise = 0;
      hr_prev = hr;
      if (cce) begin
        if (cce_since_rise < 100) cce_since_rise++;
        wrap_win = (cce_since_rise == 2);
      end
    end
  end

  logic [8:0] exp_q[$];

  task automatic drive_and_push(input logic [6:0] ich, input logic [3:0] ln,
                                input logic i_lten, input logic i_vsp, input logic i_rvv,
                                input logic i_hglt, input logic [1:0] i_gpa,
                                input logic i_blink, input logic [1:0] i_mode,
                                input logic vis, input int nwin);
    logic [7:0] fd;
    logic [5:0] gl;
    @(negedge clk);
    ichar = ich; line = ln; lten = i_lten; vsp = i_vsp; rvv = i_rvv;
    hglt = i_hglt; gpa = i_gpa; blink = i_blink; mode = i_mode;
    fd = rom_f({ich, ln[2:0]});
    gl = i_lten ? 6'h3F : (i_vsp ? 6'h00 : (fd[5:0] ^ {6{i_rvv}}));
    for (int w = 0; w < nwin; w++)
      for (int i = 0; i < CHAR_W; i++)
        exp_q.push_back(color_f(gl[5-i] & vis, i_mode, i_hglt, i_gpa));
  endtask

  task automatic run_windows(input int nwin, input string tag);
    int skip;
    int done;
    int budget;
    logic [8:0] e;
    skip = 2;
    done = 0;
    budget = 0;
    while (done < nwin && budget < 4 * LINE_CLKS * nwin) begin
      @(negedge clk); #1;
      budget++;
      if (cce) begin
        if (wrap_win) begin
        end else if (skip > 0) begin
          skip--;
        end else begin
          if (exp_q.size() < CHAR_W) begin
            check({tag, "_sb_empty"}, exp_q.size(), CHAR_W);
            return;
          end
          for (int i = 0; i < CHAR_W; i++) begin
            if (i == 0) @(negedge clk);
            else repeat (CLK_DIV) @(negedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s_px%0d", tag, i), {r, g, b}, e);
          end
          done++;
        end
      end
    end
    check({tag, "_windows"}, done, nwin);
    while (done < nwin) begin
      for (int i = 0; i < CHAR_W; i++) void'(exp_q.pop_front());
      done++;
    end
  endtask

  function automatic logic sig_sel(input int sel);
    case (sel)
      0:       return hr;
      1:       return vr;
      default: return frame_start;
    endcase
  endfunction

  task automatic count_until(input int sel, input logic lvl, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (sig_sel(sel) !== lvl && n < budget);
    if (sig_sel(sel) !== lvl) n = -1;
  endtask

  task automatic wait_frame();
    int fc0;
    int n;
    fc0 = fcount;
    n = 0;
    while (fcount == fc0 && n < 2 * FRAME_CLKS) begin
      @(negedge clk); #1;
      n++;
    end
    check("frame_wait", fcount != fc0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hr"}, hr, 1'b1);
    check({tag, "_vr"}, vr, 1'b1);
    check({tag, "_cce"}, cce, 1'b0);
    check({tag, "_fs"}, frame_start, 1'b0);
    check({tag, "_rgb"}, {r, g, b}, 9'h000);
  endtask

  task automatic check_hsync(input string tag);
    int n1, n2, n3;
    count_until(0, 1'b0, 2 * LINE_CLKS, n1);
    check({tag, "_hr_first_fall"}, n1, CLK_DIV * (HSS - 1) + 1);
    count_until(0, 1'b1, 2 * LINE_CLKS, n2);
    check({tag, "_hr_low_clks"}, n2, (HSE - HSS) * CLK_DIV);
    count_until(0, 1'b0, 2 * LINE_CLKS, n3);
    check({tag, "_line_clks"}, n2 + n3, LINE_CLKS);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int n1, n2, ph;
    ichar = 7'h41;
    line  = 4'd2;
    repeat (5) @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    check("rst0_font_addr", font_addr, 10'h000);

    @(negedge clk);
    reset_n = 1'b1;
    check_hsync("start");

    count_until(1, 1'b0, 2 * FRAME_CLKS, n1);
    check("vr_sync_found", n1 > 0, 1'b1);
    count_until(1, 1'b1, 2 * FRAME_CLKS, n2);
    check("vr_low_clks", n2, (VSE - VSS) * LINE_CLKS);

    count_until(2, 1'b1, 2 * FRAME_CLKS, n1);
    check("fs_found", n1 > 0, 1'b1);
    count_until(2, 1'b0, 4, n1);
    check("fs_width", n1, 1);
    count_until(2, 1'b1, 2 * FRAME_CLKS, n2);
    check("fs_period", n1 + n2, FRAME_CLKS);

    @(negedge clk);
    ichar = 7'h41;
    line  = 4'hA;
    repeat (2) @(negedge clk);
    #1;
    check("font_addr", font_addr, 10'h20A);

    drive_and_push(7'h41, 4'h2, 0, 0, 0, 0, 2'b00, 0, 2'd0, 1, 3);
    run_windows(3, "glyph2A");
    drive_and_push(7'h41, 4'hA, 0, 0, 1, 0, 2'b00, 0, 2'd0, 1, 3);
    run_windows(3, "glyph2A_rvv");
    drive_and_push(7'h13, 4'h5, 0, 0, 0, 0, 2'b00, 0, 2'd0, 1, 3);
    run_windows(3, "glyph_misc");
    drive_and_push(7'h41, 4'h2, 1, 0, 0, 0, 2'b00, 0, 2'd0, 1, 2);
    run_windows(2, "lten");
    drive_and_push(7'h7F, 4'h7, 0, 1, 0, 0, 2'b00, 0, 2'd0, 1, 2);
    run_windows(2, "vsp");
    drive_and_push(7'h7F, 4'h7, 0, 0, 0, 0, 2'b01, 0, 2'd2, 1, 2);
    run_windows(2, "mode2_gpa1");
    drive_and_push(7'h7F, 4'h7, 0, 0, 0, 0, 2'b00, 0, 2'd2, 1, 2);
    run_windows(2, "mode2_c0");
    drive_and_push(7'h7F, 4'h7, 0, 0, 0, 1, 2'b10, 0, 2'd2, 1, 2);
    run_windows(2, "mode2_c6");
    drive_and_push(7'h41, 4'h2, 0, 0, 0, 1, 2'b00, 0, 2'd3, 1, 2);
    run_windows(2, "mode3_hglt");
    drive_and_push(7'h7F, 4'h7, 0, 0, 0, 0, 2'b00, 0, 2'd3, 1, 2);
    run_windows(2, "mode3_plain");
    drive_and_push(7'h41, 4'h2, 0, 0, 0, 0, 2'b00, 0, 2'd1, 1, 2);
    run_windows(2, "mode1");

    for (int f = 0; f < 6; f++) begin
      wait_frame();
      ph = (fcount / BF) % 2;
      drive_and_push(7'h7F, 4'h7, 0, 0, 0, 0, 2'b00, 1, 2'd0, (ph == 0), 2);
      run_windows(2, $sformatf("blink_f%0d", fcount));
    end
    for (int f = 0; f < 3; f++) begin
      wait_frame();
      drive_and_push(7'h7F, 4'h7, 0, 0, 0, 0, 2'b00, 0, 2'd0, 1, 2);
      run_windows(2, $sformatf("noblink_f%0d", fcount));
    end

    drive_and_push(7'h7F, 4'h7, 1, 0, 0, 1, 2'b00, 0, 2'd3, 1, 0);
    repeat (2 * LINE_CLKS) @(negedge clk);
    count_until(0, 1'b0, 2 * LINE_CLKS, n1);
    check("pre_rst_rgb", {r, g, b}, 9'h1FF);
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check_reset_outputs($sformatf("rst_mid%0d", i));
    end
    @(negedge clk);
    reset_n = 1'b1;
    check_hsync("post_rst");

    check("sb_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
